// File: rtl/dp_ram_be_pipe.sv
// dp_ram_be_pipe: true dual-port RAM with byte-lane writes, deterministic same-address collision handling and an optional post-reset zero sweep.
// Latency: a read sampled at a rising edge returns dat_*_o with vld_*_o RD_LAT edges later (RD_LAT=1 -> right after the sampling edge); writes land at the sampling edge.
// Backpressure: none; each port takes one request per cycle, and requests are silently dropped while init_busy_o is high.
//
// Ports:
//   clk, rst_ni                  clock, asynchronous active-low reset
//   init_busy_o                  high while the zero sweep owns the array
//   cyc/we/be/adr/dat_{a,b}_i    per-port request (be only used for writes)
//   dat_{a,b}_o, vld_{a,b}_o     per-port read return, vld is a one-cycle pulse per read
//   coll_o, coll_cnt_o           registered collision pulse and saturating 16-bit count

module dp_ram_be_pipe #(
  parameter int DPRAM_AW  = 8,
  parameter int DPRAM_DW  = 32,
  parameter int RD_LAT    = 1,
  parameter int RDW_MODE  = 0,
  parameter int INIT_ZERO = 1
) (
  input  logic                  clk,
  input  logic                  rst_ni,
  output logic                  init_busy_o,
  input  logic                  cyc_a_i,
  input  logic                  we_a_i,
  input  logic [DPRAM_DW/8-1:0] be_a_i,
  input  logic [DPRAM_AW-1:0]   adr_a_i,
  input  logic [DPRAM_DW-1:0]   dat_a_i,
  output logic [DPRAM_DW-1:0]   dat_a_o,
  output logic                  vld_a_o,
  input  logic                  cyc_b_i,
  input  logic                  we_b_i,
  input  logic [DPRAM_DW/8-1:0] be_b_i,
  input  logic [DPRAM_AW-1:0]   adr_b_i,
  input  logic [DPRAM_DW-1:0]   dat_b_i,
  output logic [DPRAM_DW-1:0]   dat_b_o,
  output logic                  vld_b_o,
  output logic                  coll_o,
  output logic [15:0]           coll_cnt_o
);

  localparam int   NB      = DPRAM_DW / 8;
  localparam int   DEPTH   = 2 ** DPRAM_AW;
  localparam logic ST_INIT = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  if ((DPRAM_DW % 8) != 0 || DPRAM_DW < 8) begin : g_bad_dw
    $error("dp_ram_be_pipe: DPRAM_DW must be a non-zero multiple of 8");
  end
  if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_lat
    $error("dp_ram_be_pipe: RD_LAT must be in 1..3");
  end

  logic [DPRAM_DW-1:0] mem [DEPTH];

  logic                state_q;
  logic [DPRAM_AW-1:0] init_cnt_q;

  logic run;
  logic wr_a, rd_a, wr_b, rd_b;
  logic same_adr;
  logic coll_evt;
  logic [DPRAM_DW-1:0] rd_dat_a, rd_dat_b;

  assign run         = (state_q == ST_RUN);
  assign init_busy_o = (state_q == ST_INIT);

  // Requests only exist in RUN; during the sweep they vanish completely.
  assign wr_a     = run & cyc_a_i &  we_a_i;
  assign rd_a     = run & cyc_a_i & ~we_a_i;
  assign wr_b     = run & cyc_b_i &  we_b_i;
  assign rd_b     = run & cyc_b_i & ~we_b_i;
  assign same_adr = (adr_a_i == adr_b_i);

  // Read/read on one address is harmless; anything involving a write is a collision.
  assign coll_evt = run & cyc_a_i & cyc_b_i & same_adr & (we_a_i | we_b_i);

  // ---------------------------------------------------------------------------
  // Sweep / run state machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
      init_cnt_q <= '0;
    end else if (state_q == ST_INIT) begin
      init_cnt_q <= init_cnt_q + DPRAM_AW'(1);
      if (init_cnt_q == {DPRAM_AW{1'b1}}) begin
        state_q <= ST_RUN;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Array write. Port B lanes are scheduled first and port A lanes after, so on
  // a shared address A overrides B only on lanes both ports enable.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[init_cnt_q] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (wr_b && be_b_i[i]) mem[adr_b_i][i*8 +: 8] <= dat_b_i[i*8 +: 8];
      end
      for (int i = 0; i < NB; i++) begin
        if (wr_a && be_a_i[i]) mem[adr_a_i][i*8 +: 8] <= dat_a_i[i*8 +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read word selection. Read-first returns the stored word; write-first lays
  // the other port's enabled write lanes over it on an address match.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_dat_a = mem[adr_a_i];
    rd_dat_b = mem[adr_b_i];
    if (RDW_MODE == 1 && same_adr) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_b && be_b_i[i]) rd_dat_a[i*8 +: 8] = dat_b_i[i*8 +: 8];
        if (wr_a && be_a_i[i]) rd_dat_b[i*8 +: 8] = dat_a_i[i*8 +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline: RD_LAT register stages per port. Data registers only load
  // behind a valid, so the last stage naturally holds the previous read.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < RD_LAT; k++) begin : g_pipe
    logic                v_a_q, v_b_q;
    logic [DPRAM_DW-1:0] d_a_q, d_b_q;
    logic                v_a_in, v_b_in;
    logic [DPRAM_DW-1:0] d_a_in, d_b_in;

    if (k == 0) begin : g_head
      assign v_a_in = rd_a;
      assign d_a_in = rd_dat_a;
      assign v_b_in = rd_b;
      assign d_b_in = rd_dat_b;
    end else begin : g_tail
      assign v_a_in = g_pipe[k-1].v_a_q;
      assign d_a_in = g_pipe[k-1].d_a_q;
      assign v_b_in = g_pipe[k-1].v_b_q;
      assign d_b_in = g_pipe[k-1].d_b_q;
    end

    always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
        v_a_q <= 1'b0;
        v_b_q <= 1'b0;
        d_a_q <= '0;
        d_b_q <= '0;
      end else begin
        v_a_q <= v_a_in;
        v_b_q <= v_b_in;
        if (v_a_in) d_a_q <= d_a_in;
        if (v_b_in) d_b_q <= d_b_in;
      end
    end
  end

  assign vld_a_o = g_pipe[RD_LAT-1].v_a_q;
  assign dat_a_o = g_pipe[RD_LAT-1].d_a_q;
  assign vld_b_o = g_pipe[RD_LAT-1].v_b_q;
  assign dat_b_o = g_pipe[RD_LAT-1].d_b_q;

  // ---------------------------------------------------------------------------
  // Collision pulse and saturating counter, both updated at the edge after the
  // colliding one so they line up.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      coll_o     <= 1'b0;
      coll_cnt_o <= 16'h0000;
    end else begin
      coll_o <= coll_evt;
      if (coll_evt && coll_cnt_o != 16'hFFFF) begin
        coll_cnt_o <= coll_cnt_o + 16'd1;
      end
    end
  end

endmodule

// File: doc/dp_ram_be_pipe.md
Name: dp_ram_be_pipe

Overview:
True dual-port synchronous RAM that generalises the team's basic dual-port RAM. Adds byte-lane write enables and a configurable read pipeline depth with a valid strobe. Resolves same-address cross-port collisions deterministically, counts them, and optionally zero-fills the array after reset through an internal sweep state machine. Intended as the data/tag store behind the coherent interconnect's cache and directory slices.

Parameters:
DPRAM_AW, 8, address width; depth = 2**DPRAM_AW words.
DPRAM_DW, 32, data width; must be a multiple of 8 (elaboration-time assertion).
RD_LAT, 1, read latency in cycles, legal 1..3 (assertion).
RDW_MODE, 0, cross-port read-during-write: 0 = read-first (old data), 1 = write-first (new merged data).
INIT_ZERO, 1, 1 = zero-fill the array after every reset; 0 = no sweep.

Ports:
clk  in  1  clock, all logic on rising edge
rst_ni  in  1  asynchronous active-low reset
init_busy_o  out  1  high while the zero-fill sweep runs; ports ignored
cyc_a_i  in  1  port A request
we_a_i  in  1  port A write (1) / read (0)
be_a_i  in  DPRAM_DW/8  port A byte enables, writes only
adr_a_i  in  DPRAM_AW  port A address
dat_a_i  in  DPRAM_DW  port A write data
dat_a_o  out  DPRAM_DW  port A read data
vld_a_o  out  1  port A read data valid, one-cycle pulse per read
cyc_b_i, we_b_i, be_b_i, adr_b_i, dat_b_i, dat_b_o, vld_b_o: as port A, for port B
coll_o  out  1  one-cycle pulse, registered, for a same-address collision
coll_cnt_o  out  16  saturating collision counter

Behaviour:
- Reset (rst_ni low, asynchronous): dat_*_o=0, vld_*_o=0, coll_o=0, coll_cnt_o=0, read pipelines flushed. init_busy_o is 1 if INIT_ZERO=1, else 0. Array contents are not reset.
- FSM states are INIT and RUN. On reset release:
  - INIT_ZERO=1: enter INIT, with an address counter at 0.
  - INIT_ZERO=0: enter RUN.
- INIT state:
  - Writes all-zero to the counter address each cycle and increments the counter.
  - After writing address 2**DPRAM_AW-1, moves to RUN on the next edge. init_busy_o is high for exactly 2**DPRAM_AW cycles.
  - Port requests in INIT are dropped: no write, no vld, no collision.
- Reset asserted mid-sweep or mid-read: immediate return to the reset state. In-flight reads never produce vld. The sweep restarts from address 0.
- RUN state, write (cyc&&we): byte lane i of mem[adr] is updated iff be[i]. be=0 is a legal no-op. A write never pulses vld.
- RUN state, read (cyc&&!we):
  - A read issued at edge N gives dat_o valid and vld_o=1 after edge N+RD_LAT.
  - Back-to-back reads are fully pipelined, one per cycle per port.
  - dat_o holds its last read value while vld_o=0.
- Same address on A and B in the same RUN cycle, both cyc:
  - Write/write: for lanes enabled on both ports, A's data wins. Lanes enabled on only one port take that port's data. Counts as a collision.
  - Write/read: the reader gets the old word if RDW_MODE=0. If RDW_MODE=1 it gets the merged word (new bytes on enabled lanes, old bytes elsewhere). Counts as a collision.
  - Read/read: both get the same data. Not a collision.
- Collision reporting: coll_o pulses high for the cycle after the colliding edge. coll_cnt_o increments at that same time and saturates at 0xFFFF without wrapping.
- Ports are independent otherwise. Different addresses never interact.

Test Plan:
- AW=4, INIT_ZERO=1, after reset release → init_busy_o high 16 cycles. Port A write 32'hDEAD_BEEF during INIT is dropped. Reads of addr 0..15 after INIT return 0.
- RD_LAT=2: A writes 32'h1122_3344 to addr 5 with be=4'b1111, then A reads addr 5 at edge N → vld_a_o=1 and dat_a_o=32'h1122_3344 after edge N+2, one cycle wide. A back-to-back read of addr 6 follows next cycle with 0.
- Byte enables: addr 3 holds 32'hAABB_CCDD, write 32'h1122_3344 with be=4'b0101 → read returns 32'hAA22_CC44.
- Write/write collision on addr 7: A writes 32'h0000_00AA with be=4'b0001; B writes 32'h0000_BBBB with be=4'b0011 → mem[7]=32'h0000_BBAA. coll_o pulses once and coll_cnt_o=1.
- Write/read collision on addr 9 (old value 0, A writes 32'h5555_5555 be=4'b1111, B reads):
  - RDW_MODE=0 → B gets 0.
  - RDW_MODE=1 → B gets 32'h5555_5555.
  - In both cases coll_cnt_o increments.
- Force 65 540 collisions → coll_cnt_o stops at 16'hFFFF. Assert rst_ni mid-sweep at counter=7 → init_busy_o stays high, the sweep restarts at 0, and no vld appears.
